muldiv_fu_ctrl: RTL
===================

MULDIV_FU_CTRL -- requirements
Module: muldiv_fu_ctrl

Interface
REQ-001 The block SHALL have parameter TAG_WIDTH, default 5, giving the ROB tag width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_funct3 (input, 3, RV32M op), in_rs1 (input, 32), in_rs2 (input, 32) and in_tag (input, TAG_WIDTH), forming the issue handshake.
REQ-005 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_result (output, 32) and out_tag (output, TAG_WIDTH), forming the CDB handshake.
REQ-006 The block SHALL have port flush, input, 1, which squashes the in-flight op.
REQ-007 The block SHALL drive the multiplier through ports mul_start (output, 1), mul_type (output, 2; 0=uu, 1=ss, 2=su), mul_a (output, 32), mul_b (output, 32), mul_p (input, 64) and mul_done (input, 1).
REQ-008 The block SHALL drive the unsigned sequential divider through ports div_start (output, 1), div_a (output, 32), div_b (output, 32), div_q (input, 32), div_r (input, 32) and div_done (input, 1).

Function
REQ-009 The FSM SHALL have states IDLE, MUL_BUSY, DIV_BUSY, RESP and DRAIN.
REQ-010 in_ready SHALL be 1 only in IDLE; an op is accepted on in_valid&in_ready and latched together with its tag.
REQ-011 On accept, the FSM SHALL go to MUL_BUSY when funct3[2]=0 and to DIV_BUSY otherwise.
REQ-012 In MUL_BUSY, mul_start SHALL be held 1 until the cycle mul_done=1 is sampled, then drop to 0; that cycle captures the result and moves to RESP.
REQ-013 mul_type SHALL be 0 for MUL/MULHU, 1 for MULH and 2 for MULHSU; the result SHALL be mul_p[31:0] for MUL and mul_p[63:32] otherwise.
REQ-014 In DIV_BUSY, div_start SHALL pulse for exactly the first cycle.
REQ-015 For DIV/REM, div_a and div_b SHALL be the magnitudes of the operands; for DIVU/REMU they SHALL be the raw operands.
REQ-016 On div_done, the quotient SHALL be negated iff rs1 sign differs from rs2 sign (signed ops only), and the remainder SHALL take the sign of rs1.
REQ-017 A divide by zero SHALL override the unit output: DIV/DIVU return 0xFFFFFFFF, REM/REMU return rs1.
REQ-018 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0.
REQ-019 In RESP, out_valid SHALL be 1 and out_result/out_tag SHALL be held stable until out_ready=1, then the FSM returns to IDLE; there is no same-cycle re-accept.
REQ-020 With unit latency L (start to done), issue-to-out_valid latency SHALL be L+2 cycles.
REQ-021 flush in RESP SHALL go to IDLE with no output.
REQ-022 flush in MUL_BUSY or DIV_BUSY SHALL drop mul_start/div_start and go to DRAIN.
REQ-023 DRAIN SHALL wait for the pending unit's done, discard it, then go to IDLE, keeping in_ready=0 throughout.
REQ-024 flush in IDLE SHALL block accept that cycle.
REQ-025 flush SHALL have priority over a same-cycle done or out_ready.

Reset
REQ-026 On rst, the FSM SHALL enter IDLE.
REQ-027 On rst, out_valid, mul_start and div_start SHALL be 0, and out_result and out_tag SHALL be 0.
REQ-028 On rst, in_ready SHALL be 1 from the first cycle after reset.
REQ-029 Reset mid-operation SHALL abandon the op silently; no response is ever produced for it.

Configuration
REQ-030 When MULDIV_ZERO_SHORTCUT_EN is defined, an accepted MUL* op with either operand 0, or a DIV/REM op with rs2=0, SHALL bypass the units: the FSM goes IDLE->RESP, with out_valid asserted the next cycle and the result per REQ-013/REQ-017.
REQ-031 When MULDIV_ZERO_SHORTCUT_EN is undefined, every op SHALL run through its unit (the div-by-zero override still applies), and latency SHALL be per REQ-020.

Verification
REQ-032 The bench SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF, tag 3 -> out_result 0xFFFFFFFE, out_tag 3, mul_start low after done.
REQ-033 The bench SHALL cover: MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MUL -> 0x00000001.
REQ-034 The bench SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-035 The bench SHALL cover: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; with the macro defined, out_valid comes 1 cycle after accept.
REQ-036 The bench SHALL cover: flush 3 cycles into a MUL -> no out_valid, in_ready=0 until mul_done, then a new DIVU 100/7 -> 14 with the correct tag.
REQ-037 The bench SHALL cover: out_ready held 0 for 10 cycles in RESP -> out_result/out_tag stable, in_ready=0, single transfer when out_ready rises.

Source files
------------

// File: rtl/muldiv_fu_ctrl.sv
// RV32M multiply/divide functional-unit controller: issue handshake, unit sequencing,
// sign/corner-case fix-up and CDB handshake. Optional macro: MULDIV_ZERO_SHORTCUT_EN.
module muldiv_fu_ctrl #(
    parameter int unsigned TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_funct3,
    input  logic [31:0]          in_rs1,
    input  logic [31:0]          in_rs2,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [TAG_WIDTH-1:0] out_tag,
    input  logic                 flush,
    output logic                 mul_start,
    output logic [1:0]           mul_type,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic [63:0]          mul_p,
    input  logic                 mul_done,
    output logic                 div_start,
    output logic [31:0]          div_a,
    output logic [31:0]          div_b,
    input  logic [31:0]          div_q,
    input  logic [31:0]          div_r,
    input  logic                 div_done
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        MUL_BUSY,
        DIV_BUSY,
        RESP,
        DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [XLEN-1:0]        rs1_q, rs1_d;
    logic [XLEN-1:0]        rs2_q, rs2_d;
    logic                   in_ready_d;
    logic                   out_valid_d;
    logic [XLEN-1:0]        out_result_d;
    logic [TAG_WIDTH-1:0]   out_tag_d;
    logic                   mul_start_d;
    logic [1:0]             mul_type_d;
    logic [XLEN-1:0]        mul_a_d, mul_b_d;
    logic                   div_start_d;
    logic [XLEN-1:0]        div_a_d, div_b_d;

    logic                   accept_c;
    logic                   in_div_signed_c;
    logic                   div_signed_c;
    logic                   is_rem_c;
    logic                   div_by_zero_c;
    logic                   div_ovf_c;
    logic [XLEN-1:0]        quot_fix_c;
    logic [XLEN-1:0]        rem_fix_c;
    logic [XLEN-1:0]        div_res_c;
    logic [XLEN-1:0]        mul_res_c;

    assign accept_c        = in_ready & in_valid & ~flush;
    assign in_div_signed_c = ~in_funct3[0];

    // Result fix-up for the unsigned divider, using the operands latched at accept
    assign div_signed_c  = ~op_q[0];
    assign is_rem_c      = op_q[1];
    assign div_by_zero_c = (rs2_q == '0);
    assign div_ovf_c     = div_signed_c & (rs1_q == INT_MIN) & (rs2_q == '1);
    assign quot_fix_c    = (div_signed_c & (rs1_q[XLEN-1] ^ rs2_q[XLEN-1])) ? XLEN'(-div_q) : div_q;
    assign rem_fix_c     = (div_signed_c & rs1_q[XLEN-1]) ? XLEN'(-div_r) : div_r;

    always_comb begin
        if (div_by_zero_c) begin
            div_res_c = is_rem_c ? rs1_q : '1;
        end else if (div_ovf_c) begin
            div_res_c = is_rem_c ? '0 : INT_MIN;
        end else begin
            div_res_c = is_rem_c ? rem_fix_c : quot_fix_c;
        end
    end

    assign mul_res_c = (op_q[1:0] == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

`ifdef MULDIV_ZERO_SHORTCUT_EN
    logic            sc_hit_c;
    logic [XLEN-1:0] sc_res_c;

    // Results that are known without running a unit
    assign sc_hit_c = in_funct3[2] ? (in_rs2 == '0) : ((in_rs1 == '0) | (in_rs2 == '0));
    assign sc_res_c = in_funct3[2] ? (in_funct3[1] ? in_rs1 : '1) : '0;
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        out_valid_d  = out_valid;
        out_result_d = out_result;
        out_tag_d    = out_tag;
        mul_start_d  = mul_start;
        mul_type_d   = mul_type;
        mul_a_d      = mul_a;
        mul_b_d      = mul_b;
        div_start_d  = 1'b0;
        div_a_d      = div_a;
        div_b_d      = div_b;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    op_d      = in_funct3;
                    rs1_d     = in_rs1;
                    rs2_d     = in_rs2;
                    out_tag_d = in_tag;
                    mul_a_d   = in_rs1;
                    mul_b_d   = in_rs2;
                    case (in_funct3[1:0])
                        2'b01:   mul_type_d = 2'd1;
                        2'b10:   mul_type_d = 2'd2;
                        default: mul_type_d = 2'd0;
                    endcase
                    div_a_d = (in_div_signed_c & in_rs1[XLEN-1]) ? XLEN'(-in_rs1) : in_rs1;
                    div_b_d = (in_div_signed_c & in_rs2[XLEN-1]) ? XLEN'(-in_rs2) : in_rs2;
                    if (in_funct3[2]) begin
                        state_d     = DIV_BUSY;
                        div_start_d = 1'b1;
                    end else begin
                        state_d     = MUL_BUSY;
                        mul_start_d = 1'b1;
                    end
`ifdef MULDIV_ZERO_SHORTCUT_EN
                    if (sc_hit_c) begin
                        state_d      = RESP;
                        mul_start_d  = 1'b0;
                        div_start_d  = 1'b0;
                        out_valid_d  = 1'b1;
                        out_result_d = sc_res_c;
                    end
`endif
                end
            end
            MUL_BUSY: begin
                // A flush that coincides with done has nothing left to drain
                if (flush) begin
                    mul_start_d = 1'b0;
                    state_d     = mul_done ? IDLE : DRAIN;
                end else if (mul_done) begin
                    mul_start_d  = 1'b0;
                    out_valid_d  = 1'b1;
                    out_result_d = mul_res_c;
                    state_d      = RESP;
                end
            end
            DIV_BUSY: begin
                if (flush) begin
                    state_d = div_done ? IDLE : DRAIN;
                end else if (div_done) begin
                    out_valid_d  = 1'b1;
                    out_result_d = div_res_c;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (flush | out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                if (op_q[2] ? div_done : mul_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                mul_start_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            mul_start  <= 1'b0;
            mul_type   <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            div_start  <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            in_ready   <= in_ready_d;
            out_valid  <= out_valid_d;
            out_result <= out_result_d;
            out_tag    <= out_tag_d;
            mul_start  <= mul_start_d;
            mul_type   <= mul_type_d;
            mul_a      <= mul_a_d;
            mul_b      <= mul_b_d;
            div_start  <= div_start_d;
            div_a      <= div_a_d;
            div_b      <= div_b_d;
        end
    end

endmodule
